mdu_sequencer: RTL
==================

// Module: mdu_sequencer
// PURPOSE
//  Multi-cycle multiply/divide unit with HI/LO registers for the MIPS32 core.
//  It executes MULT/MULTU/DIV/DIVU (ALU_MULT/ALU_DIV), MTHI and MTLO, issued by the decode stage.
//  It exports busy/stall so the core holds issue and MFHI/MFLO until the result is final.
// PARAMETERS
//  DATA_W  32  operand and HI/LO width
//  CNT_W   6   iteration counter width; must satisfy 2**CNT_W > DATA_W
// PORTS
//  clk     in   1       core clock, rising edge
//  rst     in   1       asynchronous reset, active-high
//  start   in   1       issue request; sampled only when busy=0
//  mdu_op  in   3       `MDU_MULT/`MDU_MULTU/`MDU_DIV/`MDU_DIVU/`MDU_MTHI/`MDU_MTLO
//  op_a    in   DATA_W  rs value: multiplicand, dividend, or MT source
//  op_b    in   DATA_W  rt value: multiplier or divisor
//  flush   in   1       abort the in-flight operation (branch/exception squash)
//  mf_req  in   1       the instruction in decode is MFHI/MFLO
//  busy    out  1       an operation is in flight
//  stall   out  1       mf_req & busy, or start & busy; combinational
//  done    out  1       one-cycle pulse on the cycle HI/LO take a MULT/DIV result
//  hi, lo  out  DATA_W  architectural HI and LO registers
// BEHAVIOUR
//  - Reset: state=IDLE, hi=lo=0, busy=0, done=0, counter=0, operand regs=0. Reset mid-operation discards it.
//  - States: IDLE -> MUL | DIV -> FIN -> IDLE.
//  - IDLE, start=1, no flush:
//    - MULT/MULTU/DIV/DIVU: latch operand magnitudes and sign flags (signed ops only); go to MUL or DIV; busy=1 from the next cycle.
//    - MTHI/MTLO: write hi or lo at that edge; no busy, no done.
//  - MUL: radix-2 shift-add, one bit per cycle, DATA_W cycles, into a 2*DATA_W accumulator.
//  - DIV: restoring division, one quotient bit per cycle, DATA_W cycles, on unsigned magnitudes.
//  - Counter reaching DATA_W-1 moves the state to FIN.
//  - FIN (1 cycle): apply signs, then write hi and lo and pulse done at the exit edge.
//    - Signed product negated when sign_a^sign_b.
//    - Quotient negated when sign_a^sign_b; remainder takes sign_a.
//    - Result: MULT gives hi=prod[63:32], lo=prod[31:0]; DIV gives lo=quotient, hi=remainder.
//  - Latency: start accepted at edge E0; hi/lo valid and done=1 after edge E(DATA_W+1), i.e. E33.
//  - Divide by zero: normal iteration; result is fixed at lo=32'hFFFF_FFFF and hi=op_a (unsigned iteration result, then FIN sign fix for DIV).
//  - Signed overflow: DIV 0x8000_0000 / 0xFFFF_FFFF gives lo=0x8000_0000, hi=0.
//  - start while busy=1: ignored; stall=1 holds the requester.
//  - flush=1: next state IDLE, busy=0 next cycle, hi/lo unchanged, no done. Flush has priority over start in the same cycle.
//  - Flush arriving in FIN: the write is suppressed.
//  - done and a new start cannot overlap: start is only accepted after busy falls.
// CONFIGURATION
//  - `MDU_FAST_MULT_EN defined: MULT/MULTU go IDLE -> FIN directly, using a single-cycle DATA_W x DATA_W multiply.
//    - Result and done after edge E1. DIV is unchanged.
//  - `MDU_FAST_MULT_EN undefined: shift-add path as above; no '*' operator is synthesised.
// STRUCTURE
//  - defines.v: `MDU_OP_WIDTH, `MDU_* op encodings, `MDU_ST_IDLE/MUL/DIV/FIN state encodings, `MDU_CNT_MAX.
//  - Sub-module mdu_div_step: combinational one-bit restoring step.
//    - In: partial remainder, dividend bit, divisor.
//    - Out: next remainder, quotient bit.
//  - The FSM, counter, accumulators and HI/LO stay in mdu_sequencer.
// TESTING
//  1. MULT 0xFFFF_FFFE x 0x0000_0003 -> hi=0xFFFF_FFFF, lo=0xFFFF_FFFA; done exactly 33 cycles after start; busy high throughout.
//  2. DIVU 100/7 -> lo=14, hi=2. DIV -7/2 -> lo=0xFFFF_FFFD, hi=0xFFFF_FFFF.
//  3. DIV 5/0 -> lo=0xFFFF_FFFF, hi=5. DIV 0x8000_0000/-1 -> lo=0x8000_0000, hi=0.
//  4. MULTU 3x4, flush at cycle 10 -> no done; hi/lo keep prior values; busy=0 next cycle; new start accepted.
//  5. MTLO 0x1234 in IDLE -> lo=0x1234 next cycle. mf_req during MUL -> stall=1 until done.
//  6. rst asserted mid-DIV (asynchronous) -> hi=lo=0, busy=0 immediately. With `MDU_FAST_MULT_EN: MULT 6x7 -> lo=42 after edge E1.

Source files
------------

// File: rtl/mdu_sequencer_pkg.sv
// Shared encodings for the multiply/divide unit: operation codes, FSM states
// and small decode helpers used by the sequencer and its testbench.
package mdu_sequencer_pkg;

    localparam int MDU_OP_WIDTH = 3;

    typedef logic [MDU_OP_WIDTH-1:0] mdu_op_t;
    typedef logic [1:0]              mdu_state_t;

    localparam mdu_op_t MDU_MULT  = 3'd0;
    localparam mdu_op_t MDU_MULTU = 3'd1;
    localparam mdu_op_t MDU_DIV   = 3'd2;
    localparam mdu_op_t MDU_DIVU  = 3'd3;
    localparam mdu_op_t MDU_MTHI  = 3'd4;
    localparam mdu_op_t MDU_MTLO  = 3'd5;

    localparam mdu_state_t MDU_ST_IDLE = 2'd0;
    localparam mdu_state_t MDU_ST_MUL  = 2'd1;
    localparam mdu_state_t MDU_ST_DIV  = 2'd2;
    localparam mdu_state_t MDU_ST_FIN  = 2'd3;

    function automatic logic op_is_signed(input mdu_op_t op);
        return (op == MDU_MULT) || (op == MDU_DIV);
    endfunction

    function automatic logic op_is_mult(input mdu_op_t op);
        return (op == MDU_MULT) || (op == MDU_MULTU);
    endfunction

    function automatic logic op_is_div(input mdu_op_t op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_sequencer_div_step.sv
// One restoring-division step: shift in the next dividend bit and subtract the
// divisor when it fits. Purely combinational.
module mdu_div_step
    import mdu_sequencer_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] rem,
    input  logic              dvd_bit,
    input  logic [DATA_W-1:0] divisor,
    output logic [DATA_W-1:0] rem_next,
    output logic              q_bit
);

    logic [DATA_W:0]   shifted;
    logic [DATA_W-1:0] rem_sub;

    assign shifted  = {rem, dvd_bit};
    // The true difference is below 2**DATA_W whenever it is taken, so the
    // low DATA_W bits of the subtraction are exact.
    assign rem_sub  = shifted[DATA_W-1:0] - divisor;
    assign q_bit    = (shifted >= {1'b0, divisor});
    assign rem_next = q_bit ? rem_sub : shifted[DATA_W-1:0];

endmodule

// File: rtl/mdu_sequencer.sv
// Multi-cycle MIPS32 multiply/divide unit with architectural HI/LO registers.
// Define MDU_FAST_MULT_EN to replace the shift-add multiplier with a one-cycle multiply.
module mdu_sequencer
    import mdu_sequencer_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [MDU_OP_WIDTH-1:0] mdu_op,
    input  logic [DATA_W-1:0]       op_a,
    input  logic [DATA_W-1:0]       op_b,
    input  logic                    flush,
    input  logic                    mf_req,
    output logic                    busy,
    output logic                    stall,
    output logic                    done,
    output logic [DATA_W-1:0]       hi,
    output logic [DATA_W-1:0]       lo
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    function automatic logic [DATA_W-1:0] abs_val(input logic [DATA_W-1:0] x, input logic en);
        return (en && x[DATA_W-1]) ? -x : x;
    endfunction

    function automatic logic [DATA_W-1:0] neg_w(input logic [DATA_W-1:0] x, input logic en);
        return en ? -x : x;
    endfunction

    function automatic logic [2*DATA_W-1:0] neg_2w(input logic [2*DATA_W-1:0] x, input logic en);
        return en ? -x : x;
    endfunction

    mdu_state_t          state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [2*DATA_W-1:0] acc_q;
    logic [DATA_W-1:0]   opnd_q;
    logic                sign_a_q;
    logic                sign_b_q;
    logic                is_div_q;
    logic                done_q;
    logic [DATA_W-1:0]   hi_q;
    logic [DATA_W-1:0]   lo_q;

    logic                req_signed;
    logic [DATA_W-1:0]   mag_a;
    logic [DATA_W-1:0]   mag_b;
    logic [DATA_W-1:0]   acc_hi;
    logic [DATA_W-1:0]   acc_lo;
    logic [DATA_W:0]     mul_sum;
    logic [2*DATA_W-1:0] mul_next;
    logic [DATA_W-1:0]   div_rem;
    logic                div_qbit;
    logic [2*DATA_W-1:0] div_next;
    logic [2*DATA_W-1:0] prod_fix;
    logic [DATA_W-1:0]   hi_res;
    logic [DATA_W-1:0]   lo_res;

`ifdef MDU_FAST_MULT_EN
    logic [2*DATA_W-1:0] fast_prod;
    assign fast_prod = {{DATA_W{1'b0}}, mag_a} * {{DATA_W{1'b0}}, mag_b};
`endif

    assign busy  = (state_q != MDU_ST_IDLE);
    assign stall = busy & (mf_req | start);
    assign done  = done_q;
    assign hi    = hi_q;
    assign lo    = lo_q;

    assign req_signed = op_is_signed(mdu_op);
    assign mag_a      = abs_val(op_a, req_signed);
    assign mag_b      = abs_val(op_b, req_signed);

    assign acc_hi = acc_q[2*DATA_W-1:DATA_W];
    assign acc_lo = acc_q[DATA_W-1:0];

    // Multiply: multiplier sits in acc_lo and is consumed LSB first while the
    // partial product grows into acc_hi and shifts down.
    assign mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd_q} : '0);
    assign mul_next = {mul_sum, acc_lo[DATA_W-1:1]};

    // Divide: acc_hi holds the partial remainder, acc_lo the dividend shifting
    // out of the top while quotient bits enter at the bottom.
    mdu_div_step #(
        .DATA_W (DATA_W)
    ) u_div_step (
        .rem      (acc_hi),
        .dvd_bit  (acc_lo[DATA_W-1]),
        .divisor  (opnd_q),
        .rem_next (div_rem),
        .q_bit    (div_qbit)
    );

    assign div_next = {div_rem, acc_lo[DATA_W-2:0], div_qbit};

    always_comb begin
        prod_fix = neg_2w(acc_q, sign_a_q ^ sign_b_q);
        hi_res   = prod_fix[2*DATA_W-1:DATA_W];
        lo_res   = prod_fix[DATA_W-1:0];
        if (is_div_q) begin
            lo_res = neg_w(acc_lo, sign_a_q ^ sign_b_q);
            hi_res = neg_w(acc_hi, sign_a_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= MDU_ST_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            is_div_q <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            done_q <= 1'b0;
            if (flush) begin
                state_q <= MDU_ST_IDLE;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    MDU_ST_IDLE: begin
                        if (start) begin
                            if (op_is_mult(mdu_op)) begin
                                sign_a_q <= req_signed & op_a[DATA_W-1];
                                sign_b_q <= req_signed & op_b[DATA_W-1];
                                is_div_q <= 1'b0;
                                cnt_q    <= '0;
`ifdef MDU_FAST_MULT_EN
                                acc_q    <= fast_prod;
                                state_q  <= MDU_ST_FIN;
`else
                                acc_q    <= {{DATA_W{1'b0}}, mag_b};
                                opnd_q   <= mag_a;
                                state_q  <= MDU_ST_MUL;
`endif
                            end else if (op_is_div(mdu_op)) begin
                                sign_a_q <= req_signed & op_a[DATA_W-1];
                                sign_b_q <= req_signed & op_b[DATA_W-1];
                                is_div_q <= 1'b1;
                                cnt_q    <= '0;
                                acc_q    <= {{DATA_W{1'b0}}, mag_a};
                                opnd_q   <= mag_b;
                                state_q  <= MDU_ST_DIV;
                            end else if (mdu_op == MDU_MTHI) begin
                                hi_q <= op_a;
                            end else if (mdu_op == MDU_MTLO) begin
                                lo_q <= op_a;
                            end
                        end
                    end
                    MDU_ST_MUL, MDU_ST_DIV: begin
                        acc_q <= (state_q == MDU_ST_MUL) ? mul_next : div_next;
                        if (cnt_q == CNT_LAST) begin
                            cnt_q   <= '0;
                            state_q <= MDU_ST_FIN;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    MDU_ST_FIN: begin
                        hi_q    <= hi_res;
                        lo_q    <= lo_res;
                        done_q  <= 1'b1;
                        state_q <= MDU_ST_IDLE;
                    end
                    default: state_q <= MDU_ST_IDLE;
                endcase
            end
        end
    end

endmodule
